apb_mem_slv: RTL and testbench

APB_MEM_SLV -- requirements
Module: apb_mem_slv

---
 rtl/apb_dpmem_pkg.sv | 19 +
 rtl/apb_if.sv | 29 ++
 rtl/apb_mem_array.sv | 32 +++
 rtl/apb_mem_slv.sv | 123 ++++++++++++
 tb/tb_apb_mem_slv.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_dpmem_pkg.sv
// Shared types, FSM state encoding and default parameters for the APB memory slave.
package apb_dpmem_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 256;
  localparam int WAIT_W_DEF = 4;

  typedef logic [ADDR_W_DEF-1:0]   addr_t;
  typedef logic [DATA_W_DEF-1:0]   data_t;
  typedef logic [DATA_W_DEF/8-1:0] strb_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_e;

endpackage

// File: rtl/apb_if.sv
// APB bus bundle with master and slave views.
interface apb_if
  import apb_dpmem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_W-1:0]     PADDR;
  logic [DATA_W-1:0]     PWDATA;
  logic [DATA_W/8-1:0]   PSTRB;
  logic                  PREADY;
  logic [DATA_W-1:0]     PRDATA;
  logic                  PSLVERR;

  modport mst_mp (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slv_mp (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PREADY, PRDATA, PSLVERR
  );

endinterface

// File: rtl/apb_mem_array.sv
// Word-organised storage with per-byte write enables and a combinational read port.
module apb_mem_array #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 256,
  localparam int STRB_W = DATA_W / 8,
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [STRB_W-1:0] wstrb_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int k = 0; k < STRB_W; k++) begin
        if (wstrb_i[k]) mem_q[waddr_i][k*8 +: 8] <= wdata_i[k*8 +: 8];
      end
    end
  end

  // Indices past the end of a non-power-of-two array read as zero.
  assign rdata_o = ({1'b0, raddr_i} < DEPTH_L) ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/apb_mem_slv.sv
// APB slave in front of a byte-enabled memory, with programmable wait states
// and an error response for misaligned or out-of-range addresses.
module apb_mem_slv
  import apb_dpmem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int WAIT_W = WAIT_W_DEF
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  apb_if.slv_mp             apb,
  input  logic [WAIT_W-1:0] cfg_wait
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);

  state_e              state_q;
  logic [WAIT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]    idx_q;
  logic                err_q;
  logic                write_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   strb_q;
  logic                pready_q;
  logic [DATA_W-1:0]   prdata_q;
  logic                pslverr_q;

  logic [ADDR_W-1:0]   pidx_full;
  logic                misal;
  logic                perr;
  logic                latch_d;
  logic                done_d;
  logic                done_wr_d;
  logic                done_err_d;
  logic [IDX_W-1:0]    rd_idx_d;
  logic [DATA_W-1:0]   rdata;
  logic                mem_we;

  assign pidx_full = apb.PADDR >> OFF_W;

  if (OFF_W > 0) begin : g_align
    assign misal = |apb.PADDR[(OFF_W > 0 ? OFF_W : 1)-1:0];
  end else begin : g_no_align
    assign misal = 1'b0;
  end

  assign perr = ({1'b0, pidx_full} >= DEPTH_A) || misal;

  // A setup phase is accepted from IDLE or straight out of DONE; the completion
  // qualifiers come from the bus on that edge, otherwise from the latched copy.
  assign latch_d    = apb.PSEL && !apb.PENABLE && (state_q != ACCESS);
  assign done_d     = latch_d ? (cfg_wait == '0)
                              : ((state_q == ACCESS) && apb.PSEL && (cnt_q == WAIT_W'(1)));
  assign done_wr_d  = latch_d ? apb.PWRITE : write_q;
  assign done_err_d = latch_d ? perr : err_q;
  assign rd_idx_d   = latch_d ? pidx_full[IDX_W-1:0] : idx_q;

  assign mem_we = (state_q == DONE) && write_q && !err_q;

  apb_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk_i   (PCLK),
    .we_i    (mem_we),
    .waddr_i (idx_q),
    .wstrb_i (strb_q),
    .wdata_i (wdata_q),
    .raddr_i (rd_idx_d),
    .rdata_o (rdata)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else begin
      pready_q  <= done_d;
      pslverr_q <= done_d && done_err_d;
      prdata_q  <= (done_d && !done_wr_d && !done_err_d) ? rdata : '0;
      if (latch_d) begin
        write_q <= apb.PWRITE;
        wdata_q <= apb.PWDATA;
        strb_q  <= apb.PSTRB;
        idx_q   <= pidx_full[IDX_W-1:0];
        err_q   <= perr;
        cnt_q   <= cfg_wait;
        state_q <= (cfg_wait == '0) ? DONE : ACCESS;
      end else begin
        case (state_q)
          ACCESS: begin
            if (!apb.PSEL) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q - WAIT_W'(1);
              if (cnt_q == WAIT_W'(1)) state_q <= DONE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign apb.PREADY  = pready_q;
  assign apb.PRDATA  = prdata_q;
  assign apb.PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_mem_slv.sv
// Scoreboard-driven bench for apb_mem_slv: zero-wait, strobes, wait states,
// errors, abort, reset mid-transfer and back-to-back traffic.
module tb_apb_mem_slv;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  cfg_wait;
  int          passed = 0;
  int          total  = 0;
  logic [31:0] model [256];
  exp_t        sb [$];

  apb_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  apb_mem_slv #(
    .ADDR_W (32),
    .DATA_W (32),
    .DEPTH  (256),
    .WAIT_W (4)
  ) dut (
    .PCLK     (clk),
    .PRESETn  (rst_n),
    .apb      (bus),
    .cfg_wait (cfg_wait)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (strb[k]) r[k*8 +: 8] = data[k*8 +: 8];
    return r;
  endfunction

  // Setup phase, then access phase until PREADY (bounded); cfg_wait is
  // scrambled after setup since it must not influence the running transfer.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input logic [3:0] w,
                      output int lat, output logic [31:0] rd, output logic er);
    @(negedge clk);
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = wr;
    bus.PADDR   = addr;
    bus.PWDATA  = data;
    bus.PSTRB   = strb;
    cfg_wait    = w;
    @(negedge clk);
    bus.PENABLE = 1'b1;
    cfg_wait    = ~w;
    lat = 1;
    while (bus.PREADY !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rd = bus.PRDATA;
    er = bus.PSLVERR;
  endtask

  task automatic release_bus();
    @(negedge clk);
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
    bus.PADDR   = '0;
    bus.PWDATA  = '0;
    bus.PSTRB   = '0;
    cfg_wait    = '0;
    repeat (3) @(negedge clk);
    total++; if (bus.PREADY !== 1'b0) $display("[TB] FAIL reset_pready: got %b expected 0", bus.PREADY); else passed++;
    total++; if (bus.PRDATA !== 32'h0) $display("[TB] FAIL reset_prdata: got %h expected 0", bus.PRDATA); else passed++;
    total++; if (bus.PSLVERR !== 1'b0) $display("[TB] FAIL reset_pslverr: got %b expected 0", bus.PSLVERR); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    // PENABLE high while idle must be ignored.
    @(negedge clk);
    bus.PENABLE = 1'b1;
    bus.PSEL    = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (bus.PREADY !== 1'b0) $display("[TB] FAIL idle_penable_ignored: got %b expected 0", bus.PREADY); else passed++;
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
  endtask

  task automatic test_zero_wait();
    int lat; logic [31:0] rd; logic er; exp_t e;
    sb.push_back('{32'h0, 1'b0});
    xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 4'd0, lat, rd, er);
    model[4] = merge(model[4], 32'hDEADBEEF, 4'hF);
    e = sb.pop_front();
    total++; if (lat !== 1) $display("[TB] FAIL zw_write_latency: got %0d expected 1", lat); else passed++;
    total++; if (er !== e.err) $display("[TB] FAIL zw_write_err: got %b expected %b", er, e.err); else passed++;
    sb.push_back('{model[4], 1'b0});
    xfer(1'b0, 32'h10, 32'h0, 4'h0, 4'd0, lat, rd, er);
    e = sb.pop_front();
    total++; if (lat !== 1) $display("[TB] FAIL zw_read_latency: got %0d expected 1", lat); else passed++;
    total++; if (rd !== e.data) $display("[TB] FAIL zw_read_data: got %h expected %h", rd, e.data); else passed++;
    total++; if (er !== e.err) $display("[TB] FAIL zw_read_err: got %b expected %b", er, e.err); else passed++;
    release_bus();
    @(negedge clk);
    total++; if (bus.PRDATA !== 32'h0) $display("[TB] FAIL idle_prdata: got %h expected 0", bus.PRDATA); else passed++;
    total++; if (bus.PREADY !== 1'b0) $display("[TB] FAIL idle_pready: got %b expected 0", bus.PREADY); else passed++;
  endtask

  task automatic test_strobe();
    int lat; logic [31:0] rd; logic er; exp_t e;
    logic [31:0] wd [3] = '{32'h11223344, 32'hAABBCCDD, 32'h99999999};
    logic [3:0]  st [3] = '{4'hF, 4'h5, 4'h0};
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{32'h0, 1'b0});
      xfer(1'b1, 32'h20, wd[i], st[i], 4'd0, lat, rd, er);
      model[8] = merge(model[8], wd[i], st[i]);
      e = sb.pop_front();
      total++; if (er !== e.err) $display("[TB] FAIL strobe_write_err[%0d]: got %b expected %b", i, er, e.err); else passed++;
      release_bus();
      if (i >= 1) begin
        sb.push_back('{model[8], 1'b0});
        xfer(1'b0, 32'h20, 32'h0, 4'h0, 4'd0, lat, rd, er);
        e = sb.pop_front();
        total++; if (rd !== e.data) $display("[TB] FAIL strobe_read[%0d]: got %h expected %h", i, rd, e.data); else passed++;
        release_bus();
      end
    end
    total++; if (model[8] !== 32'h11BB33DD) $display("[TB] FAIL strobe_model: got %h expected 11bb33dd", model[8]); else passed++;
  endtask

  task automatic test_wait_states();
    int lat; logic [31:0] rd; logic er; exp_t e;
    for (int w = 1; w <= 3; w++) begin
      sb.push_back('{model[4], 1'b0});
      xfer(1'b0, 32'h10, 32'h0, 4'h0, 4'(w), lat, rd, er);
      e = sb.pop_front();
      total++; if (lat !== w + 1) $display("[TB] FAIL wait_latency[%0d]: got %0d expected %0d", w, lat, w + 1); else passed++;
      total++; if (rd !== e.data) $display("[TB] FAIL wait_data[%0d]: got %h expected %h", w, rd, e.data); else passed++;
      release_bus();
    end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd; logic er; exp_t e;
    logic [31:0] ea [3] = '{32'h400, 32'h402, 32'h11};
    logic        ew [3] = '{1'b1, 1'b0, 1'b0};
    xfer(1'b1, 32'h0, 32'h0F0F0F0F, 4'hF, 4'd0, lat, rd, er);
    model[0] = 32'h0F0F0F0F;
    release_bus();
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{32'h0, 1'b1});
      xfer(ew[i], ea[i], 32'hCAFEF00D, 4'hF, 4'd1, lat, rd, er);
      e = sb.pop_front();
      total++; if (lat !== 2) $display("[TB] FAIL err_latency[%0d]: got %0d expected 2", i, lat); else passed++;
      total++; if (er !== e.err) $display("[TB] FAIL err_pslverr[%0d]: got %b expected %b", i, er, e.err); else passed++;
      total++; if (rd !== e.data) $display("[TB] FAIL err_prdata[%0d]: got %h expected %h", i, rd, e.data); else passed++;
      release_bus();
    end
    sb.push_back('{model[0], 1'b0});
    xfer(1'b0, 32'h0, 32'h0, 4'h0, 4'd0, lat, rd, er);
    e = sb.pop_front();
    total++; if (rd !== e.data) $display("[TB] FAIL err_no_commit: got %h expected %h", rd, e.data); else passed++;
    release_bus();
  endtask

  task automatic test_abort();
    int lat; logic [31:0] rd; logic er; exp_t e; int pulses;
    xfer(1'b1, 32'h30, 32'h12345678, 4'hF, 4'd0, lat, rd, er);
    model[12] = 32'h12345678;
    release_bus();
    pulses = 0;
    @(negedge clk);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
    bus.PADDR = 32'h30; bus.PWDATA = 32'hFFFFFFFF; bus.PSTRB = 4'hF; cfg_wait = 4'd5;
    @(negedge clk);
    bus.PENABLE = 1'b1;
    @(negedge clk);
    if (bus.PREADY === 1'b1) pulses++;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.PREADY === 1'b1) pulses++;
    end
    total++; if (pulses !== 0) $display("[TB] FAIL abort_pready: got %0d pulses expected 0", pulses); else passed++;
    sb.push_back('{model[12], 1'b0});
    xfer(1'b0, 32'h30, 32'h0, 4'h0, 4'd0, lat, rd, er);
    e = sb.pop_front();
    total++; if (rd !== e.data) $display("[TB] FAIL abort_no_commit: got %h expected %h", rd, e.data); else passed++;
    release_bus();
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rd; logic er; exp_t e;
    xfer(1'b1, 32'h40, 32'h0BADF00D, 4'hF, 4'd0, lat, rd, er);
    model[16] = 32'h0BADF00D;
    release_bus();
    @(negedge clk);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
    bus.PADDR = 32'h40; bus.PWDATA = 32'h55555555; bus.PSTRB = 4'hF; cfg_wait = 4'd3;
    @(negedge clk);
    bus.PENABLE = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (bus.PREADY !== 1'b0) $display("[TB] FAIL rstmid_pready: got %b expected 0", bus.PREADY); else passed++;
    total++; if (bus.PSLVERR !== 1'b0) $display("[TB] FAIL rstmid_pslverr: got %b expected 0", bus.PSLVERR); else passed++;
    @(negedge clk);
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back('{model[16], 1'b0});
    xfer(1'b0, 32'h40, 32'h0, 4'h0, 4'd0, lat, rd, er);
    e = sb.pop_front();
    total++; if (lat !== 1) $display("[TB] FAIL rstmid_next_latency: got %0d expected 1", lat); else passed++;
    total++; if (rd !== e.data) $display("[TB] FAIL rstmid_no_commit: got %h expected %h", rd, e.data); else passed++;
    release_bus();
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] rd; logic er; exp_t e;
    logic [31:0] d; logic [3:0] s; logic [3:0] w; logic wr; int idx;
    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      xfer(1'b1, 32'h80 + 32'(i * 4), d, 4'hF, 4'd0, lat, rd, er);
      model[32 + i] = d;
    end
    for (int n = 0; n < 12; n++) begin
      idx = $urandom_range(0, 3);
      wr  = 1'($urandom_range(0, 1));
      d   = $urandom;
      s   = 4'($urandom_range(0, 15));
      w   = 4'($urandom_range(0, 2));
      sb.push_back('{wr ? 32'h0 : model[32 + idx], 1'b0});
      xfer(wr, 32'h80 + 32'(idx * 4), d, s, w, lat, rd, er);
      if (wr) model[32 + idx] = merge(model[32 + idx], d, s);
      e = sb.pop_front();
      total++; if (lat !== int'(w) + 1) $display("[TB] FAIL b2b_latency[%0d]: got %0d expected %0d", n, lat, int'(w) + 1); else passed++;
      total++; if (rd !== e.data || er !== e.err)
        $display("[TB] FAIL b2b_resp[%0d]: got %h/%b expected %h/%b", n, rd, er, e.data, e.err); else passed++;
    end
    release_bus();
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_strobe();
    test_wait_states();
    test_errors();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
